// File: rtl/i2c_slave_burst.sv
// I2C slave, burst write/read with saturating write-byte limit; optional general call under I2C_SLAVE_GENERAL_CALL_EN.
// SCL/SDA events seen 3 clk after the pins move; sda_oe moves 1 clk after a detected SCL fall; writes NACK on rx_nack or byte limit.
module i2c_slave_burst #(
    parameter int                  ADDR_LEN   = 7,
    parameter logic [ADDR_LEN-1:0] SLAVE_ADDR = 7'h5B,
    parameter int                  DATA_LEN   = 8,
    parameter int                  MAX_BYTES  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                scl_in,
    input  logic                sda_in,
    output logic                sda_oe,
    output logic [DATA_LEN-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_nack,
    output logic                tx_req,
    input  logic [DATA_LEN-1:0] tx_data,
    output logic                busy,
    output logic                gen_call
);

    localparam int BCW = $clog2(DATA_LEN + 1);
    localparam int BYW = $clog2(MAX_BYTES + 1);
    localparam int SRW = ((DATA_LEN - 1) > ADDR_LEN) ? (DATA_LEN - 1) : ADDR_LEN;
    localparam logic [BYW-1:0] MAXB = BYW'(MAX_BYTES);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK_CHK, WAIT_STOP
    } state_t;

    logic scl_s1_q, scl_s2_q, scl_prev_q;
    logic sda_s1_q, sda_s2_q, sda_prev_q;

    state_t              state_q, state_d;
    logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [BYW-1:0]      byte_cnt_q, byte_cnt_d;
    logic [SRW-1:0]      shreg_q, shreg_d;
    logic                rw_q, rw_d;
    logic                load_q, load_d;
    logic                sda_oe_q, sda_oe_d;
    logic [DATA_LEN-1:0] rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                tx_req_q, tx_req_d;
    logic                busy_q, busy_d;
    logic                gen_call_q, gen_call_d;

    logic scl_rise, scl_fall, start_det, stop_det, addr_hit, gc_hit;

    assign scl_rise  = scl_s2_q & ~scl_prev_q;
    assign scl_fall  = ~scl_s2_q & scl_prev_q;
    assign start_det = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;
    assign addr_hit  = (shreg_q[ADDR_LEN-1:0] == SLAVE_ADDR);

`ifdef I2C_SLAVE_GENERAL_CALL_EN
    assign gc_hit = (shreg_q[ADDR_LEN-1:0] == '0);
`else
    assign gc_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shreg_d    = shreg_q;
        rw_d       = rw_q;
        load_d     = load_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        gen_call_d = gen_call_q;

        if (stop_det) begin
            state_d    = IDLE;
            sda_oe_d   = 1'b0;
            gen_call_d = 1'b0;
            load_d     = 1'b0;
        end else if (start_det) begin
            state_d    = ADDR;
            sda_oe_d   = 1'b0;
            gen_call_d = 1'b0;
            load_d     = 1'b0;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        if (bit_cnt_q == BCW'(ADDR_LEN)) begin
                            // current bit is R/W; the address is already in shreg
                            rw_d      = sda_s2_q;
                            bit_cnt_d = '0;
                            if (addr_hit) begin
                                state_d = ADDR_ACK;
                            end else if (gc_hit && !sda_s2_q) begin
                                state_d    = ADDR_ACK;
                                gen_call_d = 1'b1;
                            end else begin
                                state_d = WAIT_STOP;
                            end
                        end else begin
                            shreg_d   = {shreg_q[SRW-2:0], sda_s2_q};
                            bit_cnt_d = bit_cnt_q + BCW'(1);
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall && !sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else if (scl_rise && sda_oe_q) begin
                        if (rw_q) begin
                            tx_req_d = 1'b1;
                            load_d   = 1'b1;
                            state_d  = RD_BYTE;
                        end else begin
                            bit_cnt_d = '0;
                            state_d   = WR_BYTE;
                        end
                    end
                end
                WR_BYTE: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                    end
                    if (scl_rise) begin
                        shreg_d = {shreg_q[SRW-2:0], sda_s2_q};
                        if (bit_cnt_q == BCW'(DATA_LEN - 1)) begin
                            rx_data_d  = {shreg_q[DATA_LEN-2:0], sda_s2_q};
                            rx_valid_d = 1'b1;
                            state_d    = WR_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BCW'(1);
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall && !sda_oe_q) begin
                        if (rx_nack || (byte_cnt_q == MAXB)) begin
                            state_d = WAIT_STOP;
                        end else begin
                            sda_oe_d   = 1'b1;
                            byte_cnt_d = byte_cnt_q + BYW'(1);
                        end
                    end else if (scl_rise && sda_oe_q) begin
                        bit_cnt_d = '0;
                        state_d   = WR_BYTE;
                    end
                end
                RD_BYTE: begin
                    if (scl_fall) begin
                        if (load_q) begin
                            // MSB goes straight to the pin; the rest waits in shreg
                            shreg_d                = '0;
                            shreg_d[DATA_LEN-2:0]  = tx_data[DATA_LEN-2:0];
                            sda_oe_d               = ~tx_data[DATA_LEN-1];
                            bit_cnt_d              = '0;
                            load_d                 = 1'b0;
                        end else if (bit_cnt_q == BCW'(DATA_LEN)) begin
                            sda_oe_d = 1'b0;
                            state_d  = RD_ACK_CHK;
                        end else begin
                            sda_oe_d = ~shreg_q[DATA_LEN-2];
                            shreg_d  = {shreg_q[SRW-2:0], 1'b0};
                        end
                    end else if (scl_rise && !load_q) begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
                RD_ACK_CHK: begin
                    if (scl_rise) begin
                        if (!sda_s2_q) begin
                            tx_req_d = 1'b1;
                            load_d   = 1'b1;
                            state_d  = RD_BYTE;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                WAIT_STOP: sda_oe_d = 1'b0;
                default:   state_d  = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shreg_q    <= '0;
            rw_q       <= 1'b0;
            load_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            gen_call_q <= 1'b0;
        end else begin
            scl_s1_q   <= scl_in;
            scl_s2_q   <= scl_s1_q;
            scl_prev_q <= scl_s2_q;
            sda_s1_q   <= sda_in;
            sda_s2_q   <= sda_s1_q;
            sda_prev_q <= sda_s2_q;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shreg_q    <= shreg_d;
            rw_q       <= rw_d;
            load_q     <= load_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
            gen_call_q <= gen_call_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign busy     = busy_q;
    assign gen_call = gen_call_q;

endmodule

// File: doc/i2c_slave_burst.md
I2C_SLAVE_BURST -- requirements
Module: i2c_slave_burst

Interface
REQ-001 The block SHALL have parameter ADDR_LEN, default 7, meaning slave address width in bits.
REQ-002 The block SHALL have parameter SLAVE_ADDR, default 7'h5B, meaning the address the block responds to.
REQ-003 The block SHALL have parameter DATA_LEN, default 8, meaning bits per data byte.
REQ-004 The block SHALL have parameter MAX_BYTES, default 4, meaning maximum data bytes per transfer before the block NACKs writes; minimum legal value is 1.
REQ-005 The block SHALL have port clk, input, 1 bit: the system clock; one clock, at least 8x SCL frequency.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port scl_in, input, 1 bit: raw SCL line.
REQ-008 The block SHALL have port sda_in, input, 1 bit: raw SDA line.
REQ-009 The block SHALL have port sda_oe, output, 1 bit: 1 pulls SDA low (open-drain); 0 releases SDA.
REQ-010 The block SHALL have port rx_data, output, DATA_LEN bits: last received write byte.
REQ-011 The block SHALL have port rx_valid, output, 1 bit: one-clk pulse when rx_data is updated.
REQ-012 The block SHALL have port rx_nack, input, 1 bit: 1 makes the block NACK the byte currently being received; sampled at that byte's ACK slot.
REQ-013 The block SHALL have port tx_req, output, 1 bit: one-clk pulse requesting the next read byte.
REQ-014 The block SHALL have port tx_data, input, DATA_LEN bits: read byte, held stable from tx_req until the next SCL fall.
REQ-015 The block SHALL have port busy, output, 1 bit: 1 in any state other than IDLE.
REQ-016 The block SHALL have port gen_call, output, 1 bit: 1 while the current transfer was addressed by general call.

Function
REQ-017 scl_in and sda_in SHALL pass through 2-flop synchronisers; SCL rise/fall and START/STOP detection SHALL use the synchronised signals, giving 3 clk detection latency.
REQ-018 START (SDA falls while SCL high) SHALL move the FSM to ADDR from any state, including repeated START mid-transfer; STOP (SDA rises while SCL high) SHALL move it to IDLE from any state and release sda_oe.
REQ-019 FSM states SHALL be IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK_CHK, WAIT_STOP.
REQ-020 Bits SHALL be sampled on SCL rise, MSB first; sda_oe SHALL change only on the clk after a detected SCL fall.
REQ-021 ADDR SHALL shift ADDR_LEN address bits plus R/W; on a match it SHALL drive ACK (sda_oe=1) for one SCL period, otherwise it SHALL release SDA and enter WAIT_STOP.
REQ-022 On R/W=0 the FSM SHALL enter WR_BYTE; after DATA_LEN bits it SHALL update rx_data, pulse rx_valid on the same clk as the last SCL rise detection, and in WR_ACK drive ACK unless rx_nack=1 or byte count already equals MAX_BYTES, in which case it SHALL NACK and enter WAIT_STOP.
REQ-023 On R/W=1 the block SHALL pulse tx_req on the clk of the ACK-slot SCL rise, load tx_data at the following SCL fall, and drive bits as sda_oe=~bit.
REQ-024 In RD_ACK_CHK the block SHALL release SDA and sample the master's bit: ACK leads to tx_req and RD_BYTE; NACK leads to WAIT_STOP.
REQ-025 The byte counter SHALL reset at every START, saturate at MAX_BYTES, and never wrap; the bit counter SHALL be $clog2(DATA_LEN+1) bits wide.
REQ-026 WAIT_STOP SHALL keep sda_oe=0 and ignore all bits until START or STOP.

Reset
REQ-027 While rst_n=0 the block SHALL asynchronously force the FSM to IDLE, synchronisers to 1, and sda_oe, rx_valid, tx_req, busy and gen_call to 0, with rx_data=0.
REQ-028 After reset release the block SHALL ignore the bus until it detects a START.

Configuration
REQ-029 With macro I2C_SLAVE_GENERAL_CALL_EN defined, address 0 with R/W=0 SHALL be ACKed, set gen_call=1 until STOP or START, and behave as a write; address 0 with R/W=1 SHALL be NACKed.
REQ-030 Without I2C_SLAVE_GENERAL_CALL_EN, address 0 SHALL be treated as a mismatch and gen_call SHALL be tied 0.

Verification
REQ-031 Scenario: write to 0xB6, then 0xA5, 0x3C, then STOP -> three ACKs, rx_valid twice with rx_data 0xA5 then 0x3C, busy=0 after STOP.
REQ-032 Scenario: address byte 0xA0 -> sda_oe never asserted, FSM in WAIT_STOP, no rx_valid.
REQ-033 Scenario: read from 0xB7 with tx_data 0x81 then 0x7E, master ACK then NACK -> SDA carries 0x81 and 0x7E, tx_req pulses twice, FSM in WAIT_STOP.
REQ-034 Scenario: write of 5 bytes with MAX_BYTES=4 -> bytes 1-4 ACKed, byte 5 NACKed; same result for byte 2 when rx_nack=1.
REQ-035 Scenario: rst_n low mid-byte, or repeated START after byte 1 -> sda_oe=0 at once and state IDLE, or ADDR respectively, and the new address is decoded correctly.
REQ-036 Scenario: address 0x00 written with the macro on and then off -> with it, ACK and gen_call=1; without it, NACK and gen_call=0.
